rj32_data_responder: RTL and testbench

- Responder end of the rj32 CPU data-bus req/ack handshake; replaces the fixed one-cycle `ack` echo with address decode, read-data return and wait states.
- Serves three regions: a synchronous data RAM, a write-only framebuffer port (buffered through a 4-entry FIFO toward the VGA side), and a small I/O register block (LEDs, switches, 32-bit cycle counter, FIFO status).
- Sits between the `rj32` data port and the data RAM / framebuffer write port, all in the `clk_cpu` domain.

---
 rtl/rj32_bus_pkg.sv | 30 +++
 rtl/fb_write_fifo.sv | 51 +++++
 rtl/rj32_data_responder.sv | 149 ++++++++++++++
 tb/tb_rj32_data_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rj32_bus_pkg.sv
// rj32 data-bus responder: shared address map,
// I/O offsets, FSM states and status bit layout.
package rj32_bus_pkg;

  localparam logic [13:0] RAM_BASE = 14'h0000;
  localparam logic [13:0] RAM_MASK = 14'h2000;
  localparam logic [13:0] FB_BASE  = 14'h2000;
  localparam logic [13:0] FB_MASK  = 14'h3E00;
  localparam logic [13:0] IO_BASE  = 14'h3F00;
  localparam logic [13:0] IO_MASK  = 14'h3F00;

  localparam logic [7:0] IO_LED    = 8'h00;
  localparam logic [7:0] IO_SW     = 8'h01;
  localparam logic [7:0] IO_CNTLO  = 8'h02;
  localparam logic [7:0] IO_SHADOW = 8'h03;
  localparam logic [7:0] IO_STATUS = 8'h04;

  localparam int STAT_FULL_BIT  = 3;
  localparam int STAT_EMPTY_BIT = 4;

  localparam int FB_ENTRY_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FBWAIT,
    ST_ACK,
    ST_TURN
  } state_e;

endpackage

// File: rtl/fb_write_fifo.sv
// Synchronous FIFO buffering framebuffer writes
// toward the VGA side; pointers wrap modulo DEPTH.
module fb_write_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rp_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // storage write, no reset needed on data
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rj32_data_responder.sv
// rj32 data-bus responder: decodes RAM, framebuffer
// FIFO and I/O regions, returns read data with ack.
module rj32_data_responder
  import rj32_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_AW     = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              w_en,
  input  logic [13:0]       A_data,
  input  logic [15:0]       D_out,
  output logic [15:0]       D_in,
  output logic              ack,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata,
  output logic [8:0]        fbw_A,
  output logic [7:0]        fbw_D,
  output logic              fbw_en,
  input  logic              fbw_ready,
  input  logic [7:0]        sw,
  output logic [7:0]        led,
  output logic              err_unmapped
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic [31:0]   cnt_q;
  logic [15:0]   shadow_q;
  logic [15:0]   rdata_q;
  logic [7:0]    led_q;
  logic          rd_ram_q;
  logic          unmap_q;

  logic          go;
  logic          is_ram, is_fb, is_io, io_hit;
  logic [7:0]    io_off;
  logic [15:0]   io_rd;
  logic [15:0]   status;
  logic          push, pop;
  logic          f_full, f_empty;
  logic [CW-1:0] f_count;
  logic [16:0]   f_head;

  assign go = (state_q == ST_IDLE) && req;

  // region and I/O register decode
  always_comb begin
    is_ram = (A_data & RAM_MASK) == RAM_BASE;
    is_fb  = (A_data & FB_MASK) == FB_BASE;
    is_io  = (A_data & IO_MASK) == IO_BASE;
    io_off = A_data[7:0];
    io_hit = is_io && (io_off <= IO_STATUS);
  end

  // I/O read mux, including FIFO status word
  always_comb begin
    status                 = '0;
    status[2:0]            = 3'(f_count);
    status[STAT_FULL_BIT]  = f_full;
    status[STAT_EMPTY_BIT] = f_empty;
    case (io_off)
      IO_LED:    io_rd = {8'h00, led_q};
      IO_SW:     io_rd = {8'h00, sw};
      IO_CNTLO:  io_rd = cnt_q[15:0];
      IO_SHADOW: io_rd = shadow_q;
      IO_STATUS: io_rd = status;
      default:   io_rd = '0;
    endcase
  end

  assign ram_addr  = A_data[RAM_AW-1:0];
  assign ram_wdata = D_out;
  assign ram_we    = go && w_en && is_ram;

  assign push = (go && w_en && is_fb && !f_full)
             || ((state_q == ST_FBWAIT) && !f_full);
  assign pop  = !f_empty && fbw_ready;

  // next-state logic; full-FIFO writes stall
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (req)
          state_d = (w_en && is_fb && f_full)
                  ? ST_FBWAIT : ST_ACK;
      ST_FBWAIT: if (!f_full) state_d = ST_ACK;
      ST_ACK:    state_d = ST_TURN;
      ST_TURN:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // state, counter and one-shot decode side effects
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
      led_q    <= '0;
      rd_ram_q <= 1'b0;
      unmap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + 32'd1;
      if (go) begin
        rd_ram_q <= is_ram && !w_en;
        unmap_q  <= !(is_ram || is_fb || io_hit);
        rdata_q  <= (!w_en && io_hit) ? io_rd : '0;
        if (w_en && io_hit && io_off == IO_LED)
          led_q <= D_out[7:0];
        if (!w_en && io_hit && io_off == IO_CNTLO)
          shadow_q <= cnt_q[31:16];
      end
    end
  end

  assign ack          = (state_q == ST_ACK);
  assign D_in         = ack ? (rd_ram_q ? ram_rdata : rdata_q)
                            : '0;
  assign err_unmapped = ack && unmap_q;
  assign led          = led_q;
  assign fbw_en       = !f_empty;
  assign fbw_A        = f_head[16:8];
  assign fbw_D        = f_head[7:0];

  fb_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FB_ENTRY_W)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (push),
    .din   ({A_data[8:0], D_out[7:0]}),
    .pop   (pop),
    .dout  (f_head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

endmodule

// File: tb/tb_rj32_data_responder.sv
// Directed bench for rj32_data_responder: RAM, I/O,
// counter shadow, FIFO backpressure, unmapped, reset.
module tb_rj32_data_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic        w_en;
  logic [13:0] A_data;
  logic [15:0] D_out;
  logic [15:0] D_in;
  logic        ack;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [8:0]  fbw_A;
  logic [7:0]  fbw_D;
  logic        fbw_en;
  logic        fbw_ready;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        err_unmapped;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  logic [16:0] popq[$];
  logic [15:0] mem [8192];

  always #5 clock = ~clock;

  rj32_data_responder dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .w_en         (w_en),
    .A_data       (A_data),
    .D_out        (D_out),
    .D_in         (D_in),
    .ack          (ack),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata),
    .fbw_A        (fbw_A),
    .fbw_D        (fbw_D),
    .fbw_en       (fbw_en),
    .fbw_ready    (fbw_ready),
    .sw           (sw),
    .led          (led),
    .err_unmapped (err_unmapped)
  );

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clock) begin
    #1;
    if (ram_we) we_cnt++;
    if (fbw_en && fbw_ready) popq.push_back({fbw_A, fbw_D});
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic req_start(input logic w,
                           input logic [13:0] a,
                           input logic [15:0] d);
    @(negedge clock);
    req = 1'b1; w_en = w; A_data = a; D_out = d;
  endtask

  task automatic req_wait(input int budget,
                          output int lat,
                          output logic [15:0] rd,
                          output logic er);
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      if (ack) begin
        lat = i; rd = D_in; er = err_unmapped;
        break;
      end
    end
    if (lat != 0) begin
      req = 1'b0; w_en = 1'b0;
      @(negedge clock);
      chk("ack_width", {31'b0, ack}, 0);
    end
  endtask

  task automatic xact(input logic w,
                      input logic [13:0] a,
                      input logic [15:0] d,
                      output logic [15:0] rd,
                      output int lat,
                      output logic er);
    req_start(w, a, d);
    req_wait(8, lat, rd, er);
  endtask

  logic [15:0] rd;
  int          lat;
  logic        er;

  initial begin
    reset = 1'b1; req = 1'b0; w_en = 1'b0;
    A_data = '0; D_out = '0; fbw_ready = 1'b0;
    sw = 8'h3C;
    repeat (3) @(negedge clock);
    chk("rst_ack", {31'b0, ack}, 0);
    chk("rst_din", {16'b0, D_in}, 0);
    chk("rst_we", {31'b0, ram_we}, 0);
    chk("rst_fben", {31'b0, fbw_en}, 0);
    chk("rst_led", {24'b0, led}, 0);
    chk("rst_err", {31'b0, err_unmapped}, 0);
    reset = 1'b0;

    we_cnt = 0;
    xact(1'b1, 14'h0005, 16'h1234, rd, lat, er);
    chk("ramw_lat", lat, 1);
    chk("ramw_we1", we_cnt, 1);
    xact(1'b0, 14'h0005, 16'h0000, rd, lat, er);
    chk("ramr_lat", lat, 1);
    chk("ramr_data", {16'b0, rd}, 32'h1234);
    chk("ramr_err", {31'b0, er}, 0);
    chk("ramr_we", we_cnt, 1);

    xact(1'b1, 14'h3F00, 16'hFFA5, rd, lat, er);
    chk("led_val", {24'b0, led}, 32'hA5);
    xact(1'b0, 14'h3F00, 16'h0000, rd, lat, er);
    chk("led_rd", {16'b0, rd}, 32'h00A5);
    xact(1'b0, 14'h3F01, 16'h0000, rd, lat, er);
    chk("sw_rd", {16'b0, rd}, 32'h003C);

    for (int i = 0; i < 4; i++) begin
      xact(1'b1, 14'h2000 + 14'(i),
           16'hAB50 + 16'(i), rd, lat, er);
      chk("fbw_lat", lat, 1);
    end
    xact(1'b0, 14'h3F04, 16'h0000, rd, lat, er);
    chk("stat_full", {16'b0, rd}, 32'h000C);
    xact(1'b0, 14'h2003, 16'h0000, rd, lat, er);
    chk("fb_rd0", {16'b0, rd}, 0);
    req_start(1'b1, 14'h2004, 16'hAB54);
    req_wait(5, lat, rd, er);
    chk("fb5_stall", lat, 0);
    popq.delete();
    fbw_ready = 1'b1;
    req_wait(4, lat, rd, er);
    chk("fb5_lat", lat, 2);
    repeat (6) @(negedge clock);
    chk("drain_n", popq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < popq.size())
        chk("drain_ent", {15'b0, popq[i]},
            {15'b0, 9'(i), 8'h50 + 8'(i)});
    end
    xact(1'b0, 14'h3F04, 16'h0000, rd, lat, er);
    chk("stat_empty", {16'b0, rd}, 32'h0010);

    xact(1'b0, 14'h3000, 16'h0000, rd, lat, er);
    chk("unm_lat", lat, 1);
    chk("unm_data", {16'b0, rd}, 0);
    chk("unm_err", {31'b0, er}, 1);
    xact(1'b1, 14'h3FFF, 16'h00FF, rd, lat, er);
    chk("unmw_err", {31'b0, er}, 1);
    chk("unmw_led", {24'b0, led}, 32'hA5);
    xact(1'b0, 14'h3F04, 16'h0000, rd, lat, er);
    chk("unmw_stat", {16'b0, rd}, 32'h0010);

    fbw_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      xact(1'b1, 14'h2100 + 14'(i), 16'h0060, rd, lat, er);
    req_start(1'b1, 14'h2104, 16'h0064);
    req_wait(3, lat, rd, er);
    chk("mid_stall", lat, 0);
    reset = 1'b1; req = 1'b0; w_en = 1'b0;
    @(negedge clock);
    chk("mid_ack", {31'b0, ack}, 0);
    reset = 1'b0;
    chk("mid_fben", {31'b0, fbw_en}, 0);
    chk("mid_led", {24'b0, led}, 0);
    xact(1'b0, 14'h0005, 16'h0000, rd, lat, er);
    chk("mid_ramlat", lat, 1);
    chk("mid_ramdat", {16'b0, rd}, 32'h1234);
    xact(1'b0, 14'h3F04, 16'h0000, rd, lat, er);
    chk("mid_stat", {16'b0, rd}, 32'h0010);

    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (65534) @(negedge clock);
    xact(1'b0, 14'h3F02, 16'h0000, rd, lat, er);
    chk("cnt_lo1", {16'b0, rd}, 32'hFFFF);
    xact(1'b0, 14'h3F03, 16'h0000, rd, lat, er);
    chk("cnt_sh0", {16'b0, rd}, 32'h0000);
    xact(1'b0, 14'h3F02, 16'h0000, rd, lat, er);
    chk("cnt_lo2", {16'b0, rd}, 32'h0005);
    xact(1'b0, 14'h3F03, 16'h0000, rd, lat, er);
    chk("cnt_sh1", {16'b0, rd}, 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
